// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_REPORT, ST_RELEASE} state_e;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Code layout expected by the downstream keypad value decoder.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;
endpackage

// File: rtl/keypad_scan_controller_if.sv
// Keypad pins plus the key-event valid/ack handshake.
interface keypad_scan_controller_if;
  logic [3:0] Rows;
  logic [3:0] Columns;
  logic [3:0] Code;
  logic       Valid;
  logic       Ack;

  modport master (input Rows, Ack, output Columns, Code, Valid);
  modport slave  (output Rows, Ack, input Columns, Code, Valid);
endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low row inputs.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] rows_sync
);
  logic [3:0] meta_q, sync_q;

  // Reset to "no row pulled low" so nothing looks pressed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= rows;
      sync_q <= meta_q;
    end
  end

  assign rows_sync = sync_q;
endmodule

// File: rtl/keypad_scan_controller.sv
// Column-strobing scanner with press/release debounce and one event per key press.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
) (
  input logic                        Clock,
  input logic                        nReset,
  keypad_scan_controller_if.master   kp
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [3:0]    rs;
  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    c_q, c_d;
  logic [1:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  key_code_t     code_q, code_d;
  logic          tick, hit;
  logic [1:0]    hit_row;

  keypad_row_sync u_sync (
    .clk       (Clock),
    .rst_n     (nReset),
    .rows      (kp.Rows),
    .rows_sync (rs)
  );

  assign tick = (div_q == DIV_LAST);

  // Lowest-index low row wins.
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) begin
        hit     = 1'b1;
        hit_row = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    case (state_q)
      ST_SCAN: if (tick) begin
        if (!hit) begin
          c_d = c_q + 2'd1;
        end else begin
          r_d   = hit_row;
          cnt_d = CW'(1);
          if (DEBOUNCE == 1) begin
            code_d  = key_code_t'{row: hit_row, col: c_q};
            state_d = ST_REPORT;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: if (tick) begin
        if (hit && hit_row == r_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            code_d  = key_code_t'{row: r_q, col: c_q};
            state_d = ST_REPORT;
          end
        end else begin
          state_d = ST_SCAN;
          c_d     = c_q + 2'd1;
        end
      end
      // Event stays latched until acknowledged, even if the key is gone.
      ST_REPORT: if (kp.Ack) begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
      ST_RELEASE: if (tick) begin
        if (rs == ROWS_IDLE) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SCAN;
            c_d     = c_q + 2'd1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      c_q     <= 2'd0;
      r_q     <= 2'd0;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign kp.Columns = ~(4'b0001 << c_q);
  assign kp.Valid   = (state_q == ST_REPORT);
  assign kp.Code    = code_q;
endmodule
